// File: rtl/ecc_pkg.sv
// ============================================================================
// Package  : ecc_pkg
// Brief    : Shared Hamming(38,32) constants and check-bit equations for the
//            FIFO write-path calculator and read-path checker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ecc_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int PARITY_BITS = 6;

    typedef logic [PARITY_BITS:1]   parity_t;
    typedef logic [PARITY_BITS-1:0] syndrome_t;

    // Highest codeword position; syndromes above it cannot name a bit.
    localparam syndrome_t LAST_POS = 6'd38;

    // Codeword position of each data bit (powers of two hold check bits).
    localparam syndrome_t DATA_POS [DATA_WIDTH] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

    // Check bit k covers every data bit whose position has bit k-1 set.
    function automatic parity_t calc_parity(input logic [DATA_WIDTH-1:0] data);
        parity_t p;
        p = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            for (int k = 1; k <= PARITY_BITS; k++) begin
                if (DATA_POS[i][k-1]) begin
                    p[k] = p[k] ^ data[i];
                end
            end
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_syndrome_decode.sv
// ============================================================================
// Module   : ecc_syndrome_decode
// Brief    : Combinational syndrome decoder: data flip mask plus SEC/DED.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ecc_syndrome_decode
    import ecc_pkg::*;
(
    input  logic [PARITY_BITS-1:0] syndrome_i,
    output logic [DATA_WIDTH-1:0]  flip_mask_o,
    output logic                   sec_o,
    output logic                   ded_o
);

    // Check-bit positions match no entry, so their mask stays clear.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_flip
        assign flip_mask_o[gi] = (syndrome_i == DATA_POS[gi]);
    end

    assign sec_o = (syndrome_i != '0) && (syndrome_i <= LAST_POS);
    assign ded_o = (syndrome_i > LAST_POS);

endmodule

`default_nettype wire

// File: rtl/ecc_checker_rd.sv
// ============================================================================
// Module   : ecc_checker_rd
// Brief    : Read-side SEC checker for the sync FIFO: two-stage pipeline with
//            sticky error status, saturating counters and last error address.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ecc_checker_rd #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int PARITY_BITS = 6,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ECC_en,
    input  logic                   rd_en_i,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [PARITY_BITS:1]   parity_in,
    input  logic                   clr_err_i,
    output logic                   rd_valid_o,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [ADDR_WIDTH-1:0]  rd_addr_o,
    output logic                   sec_o,
    output logic                   ded_o,
    output logic                   err_irq_o,
    output logic                   sec_sticky_o,
    output logic                   ded_sticky_o,
    output logic [CNT_WIDTH-1:0]   sec_cnt_o,
    output logic [CNT_WIDTH-1:0]   ded_cnt_o,
    output logic [ADDR_WIDTH-1:0]  err_addr_o
);

    import ecc_pkg::calc_parity;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Stage 1 capture
    logic                  s1_valid_q,  s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q,   s1_addr_d;
    logic [DATA_WIDTH-1:0] s1_data_q,   s1_data_d;
    logic [PARITY_BITS:1]  s1_parity_q, s1_parity_d;
    logic                  s1_ecc_en_q, s1_ecc_en_d;

    // Stage 2 results and status
    logic                  rd_valid_q,   rd_valid_d;
    logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
    logic                  sec_q,        sec_d;
    logic                  ded_q,        ded_d;
    logic                  irq_q,        irq_d;
    logic                  sec_sticky_q, sec_sticky_d;
    logic                  ded_sticky_q, ded_sticky_d;
    logic [CNT_WIDTH-1:0]  sec_cnt_q,    sec_cnt_d;
    logic [CNT_WIDTH-1:0]  ded_cnt_q,    ded_cnt_d;
    logic [ADDR_WIDTH-1:0] err_addr_q,   err_addr_d;

    logic [PARITY_BITS:1]  w_recalc;
    logic [PARITY_BITS:1]  w_syndrome;
    logic [DATA_WIDTH-1:0] w_flip;
    logic                  w_sec_raw;
    logic                  w_ded_raw;
    logic                  w_sec;
    logic                  w_ded;
    logic                  w_unused_ecc_en;

    assign w_unused_ecc_en = ^ECC_en[DATA_WIDTH-1:1];

    always_comb begin
        s1_valid_d  = rd_en_i;
        s1_addr_d   = rd_addr_i;
        s1_data_d   = data_in;
        s1_parity_d = parity_in;
        s1_ecc_en_d = ECC_en[0];
    end

    assign w_recalc   = calc_parity(s1_data_q);
    assign w_syndrome = s1_parity_q ^ w_recalc;

    ecc_syndrome_decode u_decode (
        .syndrome_i  (w_syndrome),
        .flip_mask_o (w_flip),
        .sec_o       (w_sec_raw),
        .ded_o       (w_ded_raw)
    );

    // Flags only count for valid words with ECC enabled at capture time.
    assign w_sec = s1_valid_q & s1_ecc_en_q & w_sec_raw;
    assign w_ded = s1_valid_q & s1_ecc_en_q & w_ded_raw;

    always_comb begin
        rd_valid_d = s1_valid_q;
        data_out_d = '0;
        if (s1_valid_q) begin
            data_out_d = s1_ecc_en_q ? (s1_data_q ^ w_flip) : s1_data_q;
        end
        rd_addr_d = s1_valid_q ? s1_addr_q : rd_addr_q;
        sec_d     = w_sec;
        ded_d     = w_ded;
        irq_d     = w_sec | w_ded;

        sec_sticky_d = (sec_sticky_q & ~clr_err_i) | w_sec;
        ded_sticky_d = (ded_sticky_q & ~clr_err_i) | w_ded;

        // A clear coinciding with a new error restarts the count at one.
        sec_cnt_d = clr_err_i ? '0 : sec_cnt_q;
        if (w_sec) begin
            if (clr_err_i)              sec_cnt_d = CNT_ONE;
            else if (sec_cnt_q != CNT_MAX) sec_cnt_d = sec_cnt_q + CNT_ONE;
        end
        ded_cnt_d = clr_err_i ? '0 : ded_cnt_q;
        if (w_ded) begin
            if (clr_err_i)              ded_cnt_d = CNT_ONE;
            else if (ded_cnt_q != CNT_MAX) ded_cnt_d = ded_cnt_q + CNT_ONE;
        end

        err_addr_d = clr_err_i ? '0 : err_addr_q;
        if (w_sec | w_ded) begin
            err_addr_d = s1_addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            s1_data_q    <= '0;
            s1_parity_q  <= '0;
            s1_ecc_en_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            data_out_q   <= '0;
            rd_addr_q    <= '0;
            sec_q        <= 1'b0;
            ded_q        <= 1'b0;
            irq_q        <= 1'b0;
            sec_sticky_q <= 1'b0;
            ded_sticky_q <= 1'b0;
            sec_cnt_q    <= '0;
            ded_cnt_q    <= '0;
            err_addr_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_addr_q    <= s1_addr_d;
            s1_data_q    <= s1_data_d;
            s1_parity_q  <= s1_parity_d;
            s1_ecc_en_q  <= s1_ecc_en_d;
            rd_valid_q   <= rd_valid_d;
            data_out_q   <= data_out_d;
            rd_addr_q    <= rd_addr_d;
            sec_q        <= sec_d;
            ded_q        <= ded_d;
            irq_q        <= irq_d;
            sec_sticky_q <= sec_sticky_d;
            ded_sticky_q <= ded_sticky_d;
            sec_cnt_q    <= sec_cnt_d;
            ded_cnt_q    <= ded_cnt_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign rd_valid_o   = rd_valid_q;
    assign data_out     = data_out_q;
    assign rd_addr_o    = rd_addr_q;
    assign sec_o        = sec_q;
    assign ded_o        = ded_q;
    assign err_irq_o    = irq_q;
    assign sec_sticky_o = sec_sticky_q;
    assign ded_sticky_o = ded_sticky_q;
    assign sec_cnt_o    = sec_cnt_q;
    assign ded_cnt_o    = ded_cnt_q;
    assign err_addr_o   = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_ecc_checker_rd.sv
// ============================================================================
// Module   : tb_ecc_checker_rd
// Brief    : Self-checking bench for ecc_checker_rd against a codeword model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ecc_checker_rd;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam int NR = 300;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ECC_en;
    logic          rd_en_i;
    logic [AW-1:0] rd_addr_i;
    logic [31:0]   data_in;
    logic [6:1]    parity_in;
    logic          clr_err_i;
    logic          rd_valid_o;
    logic [31:0]   data_out;
    logic [AW-1:0] rd_addr_o;
    logic          sec_o, ded_o, err_irq_o, sec_sticky_o, ded_sticky_o;
    logic [CW-1:0] sec_cnt_o, ded_cnt_o;
    logic [AW-1:0] err_addr_o;

    int n_vec = 0;
    int n_err = 0;

    // Model status
    logic          m_sec_st, m_ded_st;
    logic [CW-1:0] m_sec_cnt, m_ded_cnt;
    logic [AW-1:0] m_err_addr, m_rd_addr;

    // Random stream storage
    logic          r_en   [0:NR-1];
    logic [AW-1:0] r_addr [0:NR-1];
    logic [31:0]   r_data [0:NR-1];
    logic [5:0]    r_par  [0:NR-1];
    logic [31:0]   r_ecc  [0:NR-1];

    ecc_checker_rd #(
        .DATA_WIDTH(32), .ADDR_WIDTH(AW), .PARITY_BITS(6), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .ECC_en(ECC_en), .rd_en_i(rd_en_i),
        .rd_addr_i(rd_addr_i), .data_in(data_in), .parity_in(parity_in),
        .clr_err_i(clr_err_i), .rd_valid_o(rd_valid_o), .data_out(data_out),
        .rd_addr_o(rd_addr_o), .sec_o(sec_o), .ded_o(ded_o),
        .err_irq_o(err_irq_o), .sec_sticky_o(sec_sticky_o),
        .ded_sticky_o(ded_sticky_o), .sec_cnt_o(sec_cnt_o),
        .ded_cnt_o(ded_cnt_o), .err_addr_o(err_addr_o)
    );

    always #5 clk = ~clk;

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Check bits are the XOR of the positions of all set data bits.
    function automatic logic [5:0] m_parity(input logic [31:0] d);
        logic [5:0] p;
        int j;
        p = '0;
        j = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (!is_pow2(pos)) begin
                if (d[j]) p = p ^ pos[5:0];
                j++;
            end
        end
        return p;
    endfunction

    // Build the full codeword, syndrome = XOR of positions of set bits.
    task automatic m_decode(input logic [31:0] d, input logic [5:0] p, input bit en,
                            output logic [31:0] q, output bit sec, output bit ded);
        logic [38:1] cw;
        logic [5:0]  s;
        int j, k;
        j = 0; k = 0; s = '0;
        for (int pos = 1; pos <= 38; pos++) begin
            if (is_pow2(pos)) begin cw[pos] = p[k]; k++; end
            else              begin cw[pos] = d[j]; j++; end
        end
        for (int pos = 1; pos <= 38; pos++) if (cw[pos]) s = s ^ pos[5:0];
        q = d; sec = 0; ded = 0;
        if (en && s != 0) begin
            if (s <= 38) begin
                sec = 1;
                cw[s] = ~cw[s];
                j = 0;
                for (int pos = 1; pos <= 38; pos++) begin
                    if (!is_pow2(pos)) begin q[j] = cw[pos]; j++; end
                end
            end else begin
                ded = 1;
            end
        end
    endtask

    task automatic model_clear;
        m_sec_st = 0; m_ded_st = 0; m_sec_cnt = '0; m_ded_cnt = '0; m_err_addr = '0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        rd_en_i = 0; rd_addr_i = '0; data_in = '0; parity_in = '0;
        clr_err_i = 0; ECC_en = 32'h1;
    endtask

    task automatic drive_word(input logic [AW-1:0] a, input logic [31:0] d,
                              input logic [5:0] p, input logic [31:0] en);
        rd_en_i = 1; rd_addr_i = a; data_in = d; parity_in = p; ECC_en = en;
    endtask

    task automatic do_clear;
        idle_inputs();
        clr_err_i = 1;
        tick();
        clr_err_i = 0;
        model_clear();
    endtask

    task automatic test_reset;
        rst = 1;
        idle_inputs();
        tick(); tick();
        n_vec++;
        if ({rd_valid_o, data_out, rd_addr_o, sec_o, ded_o, err_irq_o, sec_sticky_o,
             ded_sticky_o, sec_cnt_o, ded_cnt_o, err_addr_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b data=%h addr=%h sec=%b ded=%b cnt=%h/%h, required all zero",
                     rd_valid_o, data_out, rd_addr_o, sec_o, ded_o, sec_cnt_o, ded_cnt_o);
        end
        rst = 0;
        model_clear();
        m_rd_addr = '0;
    endtask

    task automatic test_clean;
        drive_word(5'd5, 32'h0000_0001, 6'b000011, 32'h1);
        tick(); idle_inputs(); tick();
        n_vec++;
        if ({rd_valid_o, data_out, sec_o, ded_o, err_irq_o} !== {1'b1, 32'h1, 3'b000}) begin
            n_err++;
            $display("FAIL clean_word: valid=%b data=%h sec=%b ded=%b irq=%b, required 1 00000001 0 0 0",
                     rd_valid_o, data_out, sec_o, ded_o, err_irq_o);
        end
        tick();
        n_vec++;
        if ({rd_valid_o, data_out, rd_addr_o} !== {1'b0, 32'h0, 5'd5}) begin
            n_err++;
            $display("FAIL idle_after_clean: valid=%b data=%h addr=%0d, required 0 00000000 5",
                     rd_valid_o, data_out, rd_addr_o);
        end
    endtask

    task automatic test_data_error;
        do_clear();
        drive_word(5'd9, 32'h0000_0000, 6'b000011, 32'h1);
        tick(); idle_inputs(); tick();
        n_vec++;
        if ({rd_valid_o, data_out, sec_o, ded_o, err_irq_o, sec_sticky_o, sec_cnt_o, err_addr_o}
            !== {1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 5'd9}) begin
            n_err++;
            $display("FAIL data_error: data=%h sec=%b ded=%b irq=%b sticky=%b cnt=%0d eaddr=%0d, required 00000001 1 0 1 1 1 9",
                     data_out, sec_o, ded_o, err_irq_o, sec_sticky_o, sec_cnt_o, err_addr_o);
        end
        tick();
        n_vec++;
        if ({err_irq_o, sec_o, sec_cnt_o} !== {2'b00, 4'd1}) begin
            n_err++;
            $display("FAIL irq_single_pulse: irq=%b sec=%b cnt=%0d, required 0 0 1",
                     err_irq_o, sec_o, sec_cnt_o);
        end
    endtask

    task automatic test_check_bit_error;
        drive_word(5'd3, 32'hFFFF_FFFF, 6'b011100, 32'h1);
        tick(); idle_inputs(); tick();
        n_vec++;
        if ({data_out, sec_o, ded_o, sec_cnt_o, err_addr_o} !== {32'hFFFF_FFFF, 2'b10, 4'd2, 5'd3}) begin
            n_err++;
            $display("FAIL check_bit_error: data=%h sec=%b ded=%b cnt=%0d eaddr=%0d, required ffffffff 1 0 2 3",
                     data_out, sec_o, ded_o, sec_cnt_o, err_addr_o);
        end
    endtask

    task automatic test_uncorrectable;
        drive_word(5'd17, 32'h7DFF_FFFF, 6'b011000, 32'h1);
        tick(); idle_inputs(); tick();
        n_vec++;
        if ({data_out, sec_o, ded_o, err_irq_o, ded_sticky_o, ded_cnt_o, sec_cnt_o, err_addr_o}
            !== {32'h7DFF_FFFF, 4'b0111, 4'd1, 4'd2, 5'd17}) begin
            n_err++;
            $display("FAIL uncorrectable: data=%h sec=%b ded=%b irq=%b dsticky=%b dcnt=%0d scnt=%0d eaddr=%0d, required 7dffffff 0 1 1 1 1 2 17",
                     data_out, sec_o, ded_o, err_irq_o, ded_sticky_o, ded_cnt_o, sec_cnt_o, err_addr_o);
        end
    endtask

    task automatic test_ecc_disabled;
        drive_word(5'd21, 32'h0000_0000, 6'b000011, 32'hFFFF_FFFE);
        tick(); idle_inputs(); tick();
        n_vec++;
        if ({rd_valid_o, data_out, sec_o, ded_o, err_irq_o, sec_cnt_o, ded_cnt_o, err_addr_o}
            !== {1'b1, 32'h0, 3'b000, 4'd2, 4'd1, 5'd17}) begin
            n_err++;
            $display("FAIL ecc_disabled: data=%h sec=%b ded=%b irq=%b scnt=%0d dcnt=%0d eaddr=%0d, required 00000000 0 0 0 2 1 17",
                     data_out, sec_o, ded_o, err_irq_o, sec_cnt_o, ded_cnt_o, err_addr_o);
        end
        m_rd_addr = 5'd21;
    endtask

    task automatic test_random;
        logic [31:0] q, e;
        bit          s, dd, ev;
        int          mode, i, j;
        do_clear();
        for (int t = 0; t < NR; t++) begin
            r_en[t]   = ($urandom_range(0, 3) != 0);
            r_addr[t] = AW'($urandom_range(0, 31));
            r_data[t] = $urandom;
            r_par[t]  = m_parity(r_data[t]);
            e         = $urandom;
            r_ecc[t]  = {e[31:1], ($urandom_range(0, 9) != 0)};
            mode      = $urandom_range(0, 3);
            if (mode == 1) begin
                i = $urandom_range(0, 31);
                r_data[t][i] = ~r_data[t][i];
            end else if (mode == 2) begin
                i = $urandom_range(0, 5);
                r_par[t][i] = ~r_par[t][i];
            end else if (mode == 3) begin
                i = $urandom_range(0, 37);
                j = (i + $urandom_range(1, 37)) % 38;
                if (i < 32) r_data[t][i] = ~r_data[t][i]; else r_par[t][i-32] = ~r_par[t][i-32];
                if (j < 32) r_data[t][j] = ~r_data[t][j]; else r_par[t][j-32] = ~r_par[t][j-32];
            end
        end
        for (int t = 0; t < NR + 2; t++) begin
            ev = 0; q = '0; s = 0; dd = 0;
            if (t >= 2 && r_en[t-2]) begin
                ev = 1;
                m_decode(r_data[t-2], r_par[t-2], r_ecc[t-2][0], q, s, dd);
                m_rd_addr = r_addr[t-2];
                if (s)  begin m_sec_st = 1; if (m_sec_cnt != 4'hF) m_sec_cnt++; end
                if (dd) begin m_ded_st = 1; if (m_ded_cnt != 4'hF) m_ded_cnt++; end
                if (s || dd) m_err_addr = r_addr[t-2];
            end
            n_vec++;
            if ({rd_valid_o, data_out, rd_addr_o, sec_o, ded_o, err_irq_o}
                !== {ev, q, m_rd_addr, s, dd, s | dd}) begin
                n_err++;
                $display("FAIL random_word[%0d]: valid=%b data=%h addr=%0d sec=%b ded=%b irq=%b, required %b %h %0d %b %b %b",
                         t, rd_valid_o, data_out, rd_addr_o, sec_o, ded_o, err_irq_o,
                         ev, q, m_rd_addr, s, dd, s | dd);
            end
            n_vec++;
            if ({sec_sticky_o, ded_sticky_o, sec_cnt_o, ded_cnt_o, err_addr_o}
                !== {m_sec_st, m_ded_st, m_sec_cnt, m_ded_cnt, m_err_addr}) begin
                n_err++;
                $display("FAIL random_status[%0d]: sticky=%b%b cnt=%0d/%0d eaddr=%0d, required %b%b %0d/%0d %0d",
                         t, sec_sticky_o, ded_sticky_o, sec_cnt_o, ded_cnt_o, err_addr_o,
                         m_sec_st, m_ded_st, m_sec_cnt, m_ded_cnt, m_err_addr);
            end
            if (t < NR) drive_word(r_addr[t], r_data[t], r_par[t], r_ecc[t]);
            else        idle_inputs();
            if (t < NR && !r_en[t]) rd_en_i = 0;
            tick();
        end
    endtask

    task automatic test_back_to_back_saturation;
        logic [31:0] d;
        int          b;
        do_clear();
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            b = i % 32;
            drive_word(AW'(i), d ^ (32'h1 << b), m_parity(d), 32'h1);
            tick();
        end
        idle_inputs();
        tick();
        n_vec++;
        if ({sec_cnt_o, sec_sticky_o, err_addr_o} !== {4'd15, 1'b1, 5'd19}) begin
            n_err++;
            $display("FAIL sec_saturation: cnt=%0d sticky=%b eaddr=%0d, required 15 1 19",
                     sec_cnt_o, sec_sticky_o, err_addr_o);
        end
        drive_word(5'd7, 32'h0000_0000, 6'b000011, 32'h1);
        tick();
        idle_inputs();
        clr_err_i = 1;
        tick();
        n_vec++;
        if ({sec_cnt_o, sec_sticky_o, err_addr_o, data_out} !== {4'd1, 1'b1, 5'd7, 32'h1}) begin
            n_err++;
            $display("FAIL clear_with_error: cnt=%0d sticky=%b eaddr=%0d data=%h, required 1 1 7 00000001",
                     sec_cnt_o, sec_sticky_o, err_addr_o, data_out);
        end
        tick();
        clr_err_i = 0;
        n_vec++;
        if ({sec_cnt_o, ded_cnt_o, sec_sticky_o, ded_sticky_o, err_addr_o} !== '0) begin
            n_err++;
            $display("FAIL clear_only: cnt=%0d/%0d sticky=%b%b eaddr=%0d, required all zero",
                     sec_cnt_o, ded_cnt_o, sec_sticky_o, ded_sticky_o, err_addr_o);
        end
        model_clear();
    endtask

    task automatic test_reset_midstream;
        logic [31:0] d;
        drive_word(5'd11, 32'h0000_0000, 6'b000011, 32'h1);
        tick();
        drive_word(5'd12, 32'h1234_5678, m_parity(32'h1234_5678), 32'h1);
        rst = 1;
        #1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({rd_valid_o, data_out, rd_addr_o, sec_o, ded_o, err_irq_o, sec_sticky_o,
                 ded_sticky_o, sec_cnt_o, ded_cnt_o, err_addr_o} !== '0) begin
                n_err++;
                $display("FAIL reset_midstream[%0d]: valid=%b data=%h addr=%0d sec=%b ded=%b, required all zero",
                         i, rd_valid_o, data_out, rd_addr_o, sec_o, ded_o);
            end
            tick();
        end
        rst = 0;
        d = $urandom;
        drive_word(5'd30, d, m_parity(d), 32'h1);
        tick(); idle_inputs(); tick();
        n_vec++;
        if ({rd_valid_o, data_out, rd_addr_o, sec_o, ded_o} !== {1'b1, d, 5'd30, 2'b00}) begin
            n_err++;
            $display("FAIL read_after_reset: valid=%b data=%h addr=%0d sec=%b ded=%b, required 1 %h 30 0 0",
                     rd_valid_o, data_out, rd_addr_o, sec_o, ded_o, d);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_clean();
        test_data_error();
        test_check_bit_error();
        test_uncorrectable();
        test_ecc_disabled();
        test_random();
        test_back_to_back_saturation();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
